// File: rtl/ahb_pkg.sv
// Shared AHB definitions for the manager: transfer types, size codes,
// FSM state encoding and small elaboration-time helpers.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ADDR  = 3'd1;
  localparam state_t ST_BURST = 3'd2;
  localparam state_t ST_LAST  = 3'd3;
  localparam state_t ST_ERR   = 3'd4;

  // Largest hsize code a data bus of data_w bits can carry.
  function automatic logic [2:0] max_hsize(input int unsigned data_w);
    if (data_w >= 64) return HSIZE_DWORD;
    if (data_w >= 32) return HSIZE_WORD;
    if (data_w >= 16) return HSIZE_HALF;
    return HSIZE_BYTE;
  endfunction

  // Zero beats means one; anything above max_beats is clamped.
  function automatic int unsigned clamp_beats(input logic [2:0] beats,
                                              input int unsigned max_beats);
    int unsigned b;
    b = 32'(beats);
    if (b == 0) b = 1;
    if (b > max_beats) b = max_beats;
    return b;
  endfunction

endpackage

// File: rtl/ahb_manager_addr_gen.sv
// Burst address generator and beat counter.
// Ports: clk/rst_n; load latches start_addr and beats_m1 (beats minus one);
// advance steps addr by 2^size (wrapping) and counts down; last_c is high
// while the address currently on the bus belongs to the final beat.
module ahb_manager_addr_gen #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [2:0]        size,
  input  logic [CNT_W-1:0]  beats_m1,
  output logic [ADDR_W-1:0] addr,
  output logic              last_c
);

  logic [CNT_W-1:0] remain_q;

  // Address and remaining-beat registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr     <= '0;
      remain_q <= '0;
    end else if (load) begin
      addr     <= start_addr;
      remain_q <= beats_m1;
    end else if (advance) begin
      addr     <= addr + (ADDR_W'(1) << size);
      remain_q <= remain_q - CNT_W'(1);
    end
  end

  assign last_c = (remain_q == '0);

endmodule

// File: rtl/ahb_manager.sv
// Command-driven AHB manager issuing pipelined incrementing bursts.
// Ports: hclk/hreset_n; command channel cmd_valid/cmd_ready with write flag,
// start address, size and beat count; wr_data/wr_ready write beat stream;
// rd_data/rd_valid read beat stream; done/err completion pulses;
// haddr/htrans/hwrite/hsize/hwdata AHB manager outputs; hrdata/hready/hresp
// subordinate responses.
module ahb_manager
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BEATS = 4
) (
  input  logic              hclk,
  input  logic              hreset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_beats,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp
);

  localparam int unsigned CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [2:0]  MAX_HSIZE = max_hsize(DATA_W);

  state_t              state_q, state_d;
  htrans_t             htrans_q, htrans_d, htrans_c;
  logic                hwrite_q, hwrite_d;
  logic [2:0]          hsize_q, hsize_d;
  logic [DATA_W-1:0]   hwdata_q, hwdata_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                cmd_ready_q;
  logic                load_c, advance_c, last_c, addr_go_c, wr_ready_c;
  logic                size_bad_c;
  logic [CNT_W-1:0]    beats_m1_c;

  assign size_bad_c = (cmd_size > MAX_HSIZE);
  assign beats_m1_c = CNT_W'(clamp_beats(cmd_beats, MAX_BEATS) - 1);

  ahb_manager_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk        (hclk),
    .rst_n      (hreset_n),
    .load       (load_c),
    .advance    (advance_c),
    .start_addr (cmd_addr),
    .size       (hsize_q),
    .beats_m1   (beats_m1_c),
    .addr       (haddr),
    .last_c     (last_c)
  );

  // Next-state and output decode.
  always_comb begin
    state_d    = state_q;
    htrans_d   = htrans_q;
    htrans_c   = htrans_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hwdata_d   = hwdata_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    load_c     = 1'b0;
    advance_c  = 1'b0;
    addr_go_c  = 1'b0;
    wr_ready_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (size_bad_c) begin
            err_d = 1'b1;
          end else begin
            load_c   = 1'b1;
            htrans_d = HTRANS_NONSEQ;
            hwrite_d = cmd_write;
            hsize_d  = cmd_size;
            state_d  = ST_ADDR;
          end
        end
      end
      ST_ADDR: addr_go_c = hready;
      ST_BURST, ST_LAST: begin
        if (hresp) begin
          // First error cycle cancels the pending address phase at once.
          htrans_c = HTRANS_IDLE;
          htrans_d = HTRANS_IDLE;
          if (hready) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ERR;
          end
        end else if (hready) begin
          if (!hwrite_q) begin
            rd_data_d  = hrdata;
            rd_valid_d = 1'b1;
          end
          if (state_q == ST_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            addr_go_c = 1'b1;
          end
        end
      end
      ST_ERR: begin
        if (hready) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Address phase on the bus accepted: consume write data, step the burst.
    if (addr_go_c) begin
      if (hwrite_q) begin
        wr_ready_c = 1'b1;
        hwdata_d   = wr_data;
      end
      if (last_c) begin
        htrans_d = HTRANS_IDLE;
        state_d  = ST_LAST;
      end else begin
        advance_c = 1'b1;
        htrans_d  = HTRANS_SEQ;
        state_d   = ST_BURST;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= ST_IDLE;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsize_q     <= HSIZE_BYTE;
      hwdata_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hwdata_q    <= hwdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_ready_q <= (state_d == ST_IDLE);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_ready  = wr_ready_c;
  assign htrans    = htrans_c;
  assign hwrite    = hwrite_q;
  assign hsize     = hsize_q;
  assign hwdata    = hwdata_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ahb_manager.sv
// Directed bench for ahb_manager with hand-computed per-cycle expectations.
module tb_ahb_manager;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr, cmd_size, cmd_beats;
  logic [7:0] wr_data, rd_data, hwdata, hrdata;
  logic       wr_ready, rd_valid, done, err;
  logic [2:0] haddr, hsize;
  logic [1:0] htrans;
  logic       hwrite, hready, hresp;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 hclk = ~hclk;

  ahb_manager #(.ADDR_W(3), .DATA_W(8), .MAX_BEATS(4)) dut (
    .hclk(hclk), .hreset_n(hreset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_beats(cmd_beats),
    .wr_data(wr_data), .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp)
  );

  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [2:0] a, input logic [2:0] s,
                          input logic [2:0] b);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_beats = b;
  endtask

  task automatic test_reset();
    hreset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = '0; cmd_beats = '0; wr_data = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
    cyc(); cyc(); #1;
    total_cnt++;
    if ({cmd_ready, wr_ready, rd_valid, done, err} !== 5'b0)
      $display("FAIL rst_flags: got %b expected 00000", {cmd_ready, wr_ready, rd_valid, done, err});
    else pass_cnt++;
    total_cnt++;
    if ({htrans, haddr, hwrite, hsize, hwdata, rd_data} !== 25'd0)
      $display("FAIL rst_bus: got %0h expected 0", {htrans, haddr, hwrite, hsize, hwdata, rd_data});
    else pass_cnt++;
    hreset_n = 1'b1;
    cyc(); #1;
    total_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL rst_release_ready: got %b expected 1", cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_single_write();
    cyc(); send_cmd(1'b1, 3'd2, 3'd0, 3'd1); wr_data = 8'hA5; hready = 1'b1; #1;
    total_cnt++;
    if (cmd_ready !== 1'b1) $display("FAIL sw_ready_T: got %b expected 1", cmd_ready);
    else pass_cnt++;
    cyc(); cmd_valid = 1'b0; #1;
    total_cnt++;
    if ({htrans, haddr, hwrite, wr_ready, cmd_ready} !== {2'b10, 3'd2, 1'b1, 1'b1, 1'b0})
      $display("FAIL sw_addr_T1: got tr=%b a=%0d w=%b wrr=%b rdy=%b expected tr=10 a=2 w=1 wrr=1 rdy=0",
               htrans, haddr, hwrite, wr_ready, cmd_ready);
    else pass_cnt++;
    cyc(); wr_data = 8'h00; #1;
    total_cnt++;
    if ({htrans, hwdata, done, wr_ready} !== {2'b00, 8'hA5, 1'b0, 1'b0})
      $display("FAIL sw_data_T2: got tr=%b hwdata=%0h done=%b wrr=%b expected tr=00 hwdata=a5 done=0 wrr=0",
               htrans, hwdata, done, wr_ready);
    else pass_cnt++;
    cyc(); #1;
    total_cnt++;
    if ({done, cmd_ready} !== 2'b11) $display("FAIL sw_done_T3: got %b expected 11", {done, cmd_ready});
    else pass_cnt++;
    cyc(); #1;
    total_cnt++;
    if (done !== 1'b0) $display("FAIL sw_done_T4: got %b expected 0", done);
    else pass_cnt++;
  endtask

  task automatic test_read_wrap();
    logic [7:0] rdat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [1:0] exp_tr [6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    logic [2:0] exp_ad [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    int nvalid = 0;
    int ndone = 0;
    logic exp_v;
    cyc(); send_cmd(1'b0, 3'd6, 3'd0, 3'd4); hready = 1'b1; #1;
    for (int k = 1; k <= 7; k++) begin
      cyc(); cmd_valid = 1'b0;
      if (k >= 2 && k <= 5) hrdata = rdat[k-2]; else hrdata = 8'h00;
      #1;
      if (k <= 6) begin
        total_cnt++;
        if (htrans !== exp_tr[k-1]) $display("FAIL rw_htrans c%0d: got %b expected %b", k, htrans, exp_tr[k-1]);
        else pass_cnt++;
      end
      if (k <= 4) begin
        total_cnt++;
        if (haddr !== exp_ad[k-1]) $display("FAIL rw_haddr c%0d: got %0d expected %0d", k, haddr, exp_ad[k-1]);
        else pass_cnt++;
      end
      exp_v = (k >= 3 && k <= 6);
      total_cnt++;
      if (rd_valid !== exp_v) $display("FAIL rw_rd_valid c%0d: got %b expected %b", k, rd_valid, exp_v);
      else pass_cnt++;
      if (exp_v) begin
        total_cnt++;
        if (rd_data !== rdat[k-3]) $display("FAIL rw_rd_data c%0d: got %0h expected %0h", k, rd_data, rdat[k-3]);
        else pass_cnt++;
      end
      if (rd_valid === 1'b1) nvalid++;
      if (done === 1'b1) ndone++;
    end
    total_cnt++;
    if (nvalid != 4) $display("FAIL rw_valid_count: got %0d expected 4", nvalid);
    else pass_cnt++;
    total_cnt++;
    if (ndone != 1) $display("FAIL rw_done_count: got %0d expected 1", ndone);
    else pass_cnt++;
  endtask

  task automatic test_write_wait();
    logic       hr     [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] exp_tr [6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    logic [2:0] exp_ad [5] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd2};
    logic [7:0] exp_wd [5] = '{8'hA0, 8'hB1, 8'hB1, 8'hB1, 8'hC2};
    logic       exp_wr [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int nwr = 0;
    cyc(); send_cmd(1'b1, 3'd0, 3'd0, 3'd3); #1;
    for (int k = 1; k <= 7; k++) begin
      cyc(); cmd_valid = 1'b0; hready = hr[k-1];
      if (k == 1) wr_data = 8'hA0; else if (k == 2) wr_data = 8'hB1; else wr_data = 8'hC2;
      #1;
      if (k <= 6) begin
        total_cnt++;
        if (htrans !== exp_tr[k-1]) $display("FAIL ww_htrans c%0d: got %b expected %b", k, htrans, exp_tr[k-1]);
        else pass_cnt++;
      end
      if (k <= 5) begin
        total_cnt++;
        if (haddr !== exp_ad[k-1]) $display("FAIL ww_haddr c%0d: got %0d expected %0d", k, haddr, exp_ad[k-1]);
        else pass_cnt++;
      end
      if (k >= 2 && k <= 6) begin
        total_cnt++;
        if (hwdata !== exp_wd[k-2]) $display("FAIL ww_hwdata c%0d: got %0h expected %0h", k, hwdata, exp_wd[k-2]);
        else pass_cnt++;
      end
      total_cnt++;
      if (wr_ready !== exp_wr[k-1]) $display("FAIL ww_wr_ready c%0d: got %b expected %b", k, wr_ready, exp_wr[k-1]);
      else pass_cnt++;
      if (wr_ready === 1'b1) nwr++;
      total_cnt++;
      if (done !== (k == 7)) $display("FAIL ww_done c%0d: got %b expected %b", k, done, (k == 7));
      else pass_cnt++;
    end
    total_cnt++;
    if (nwr != 3) $display("FAIL ww_wr_ready_count: got %0d expected 3", nwr);
    else pass_cnt++;
    hready = 1'b1;
  endtask

  task automatic test_read_error();
    logic       hr     [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       hs     [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] exp_tr [5] = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
    int nvalid = 0;
    int nerr = 0;
    int ndone = 0;
    cyc(); send_cmd(1'b0, 3'd4, 3'd0, 3'd4); #1;
    for (int k = 1; k <= 6; k++) begin
      cyc(); cmd_valid = 1'b0; hready = hr[k-1]; hresp = hs[k-1];
      if (k == 2) hrdata = 8'h5A; else if (k == 3) hrdata = 8'h77; else hrdata = 8'h66;
      #1;
      if (k <= 5) begin
        total_cnt++;
        if (htrans !== exp_tr[k-1]) $display("FAIL re_htrans c%0d: got %b expected %b", k, htrans, exp_tr[k-1]);
        else pass_cnt++;
      end
      if (k == 3) begin
        total_cnt++;
        if ({rd_valid, rd_data} !== {1'b1, 8'h5A})
          $display("FAIL re_rd_beat0: got v=%b d=%0h expected v=1 d=5a", rd_valid, rd_data);
        else pass_cnt++;
      end
      if (k == 5) begin
        total_cnt++;
        if ({err, cmd_ready} !== 2'b11) $display("FAIL re_err_pulse: got %b expected 11", {err, cmd_ready});
        else pass_cnt++;
      end
      if (rd_valid === 1'b1) nvalid++;
      if (err === 1'b1) nerr++;
      if (done === 1'b1) ndone++;
    end
    total_cnt++;
    if ({nvalid, nerr, ndone} !== {32'd1, 32'd1, 32'd0})
      $display("FAIL re_counts: got valid=%0d err=%0d done=%0d expected 1 1 0", nvalid, nerr, ndone);
    else pass_cnt++;
    hresp = 1'b0; hready = 1'b1;
  endtask

  task automatic test_bad_size();
    cyc(); send_cmd(1'b1, 3'd3, 3'd1, 3'd1); #1;
    cyc(); cmd_valid = 1'b0; #1;
    total_cnt++;
    if ({err, htrans, cmd_ready} !== {1'b1, 2'b00, 1'b1})
      $display("FAIL bs_err_T1: got err=%b tr=%b rdy=%b expected err=1 tr=00 rdy=1", err, htrans, cmd_ready);
    else pass_cnt++;
    cyc(); #1;
    total_cnt++;
    if ({err, htrans} !== 3'b000) $display("FAIL bs_T2: got %b expected 000", {err, htrans});
    else pass_cnt++;
  endtask

  task automatic test_clamp();
    int naddr = 0;
    int nvalid = 0;
    int ndone = 0;
    // Zero beats behaves as a single beat.
    cyc(); send_cmd(1'b0, 3'd5, 3'd0, 3'd0); #1;
    cyc(); cmd_valid = 1'b0; #1;
    total_cnt++;
    if ({htrans, haddr} !== {2'b10, 3'd5}) $display("FAIL cz_addr: got %b expected 10101", {htrans, haddr});
    else pass_cnt++;
    cyc(); hrdata = 8'h3C; #1;
    total_cnt++;
    if (htrans !== 2'b00) $display("FAIL cz_last: got %b expected 00", htrans);
    else pass_cnt++;
    cyc(); #1;
    total_cnt++;
    if ({done, rd_valid, rd_data} !== {1'b1, 1'b1, 8'h3C})
      $display("FAIL cz_done: got done=%b v=%b d=%0h expected 1 1 3c", done, rd_valid, rd_data);
    else pass_cnt++;
    // Seven beats clamps to four.
    cyc(); send_cmd(1'b0, 3'd0, 3'd0, 3'd7); hrdata = 8'hE7; #1;
    for (int k = 1; k <= 10; k++) begin
      cyc(); cmd_valid = 1'b0; #1;
      if (htrans[1] === 1'b1) naddr++;
      if (rd_valid === 1'b1) nvalid++;
      if (done === 1'b1) ndone++;
    end
    total_cnt++;
    if ({naddr, nvalid, ndone} !== {32'd4, 32'd4, 32'd1})
      $display("FAIL c7_counts: got addr=%0d valid=%0d done=%0d expected 4 4 1", naddr, nvalid, ndone);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    cyc(); send_cmd(1'b1, 3'd3, 3'd0, 3'd4); wr_data = 8'h9C; #1;
    cyc(); cmd_valid = 1'b0; #1;
    cyc(); #1;
    total_cnt++;
    if ({htrans, haddr, hwdata} !== {2'b11, 3'd4, 8'h9C})
      $display("FAIL mr_pre: got tr=%b a=%0d wd=%0h expected 11 4 9c", htrans, haddr, hwdata);
    else pass_cnt++;
    #1; hreset_n = 1'b0; #1;
    total_cnt++;
    if ({cmd_ready, wr_ready, rd_valid, done, err} !== 5'b0)
      $display("FAIL mr_flags: got %b expected 00000", {cmd_ready, wr_ready, rd_valid, done, err});
    else pass_cnt++;
    total_cnt++;
    if ({htrans, haddr, hwrite, hsize, hwdata, rd_data} !== 25'd0)
      $display("FAIL mr_bus: got %0h expected 0", {htrans, haddr, hwrite, hsize, hwdata, rd_data});
    else pass_cnt++;
    cyc(); hreset_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc(); #1;
      total_cnt++;
      if ({done, err, cmd_ready} !== 3'b001)
        $display("FAIL mr_after c%0d: got done/err/rdy=%b expected 001", k, {done, err, cmd_ready});
      else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_wrap();
    test_write_wait();
    test_read_error();
    test_bad_size();
    test_clamp();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_manager.md
AHB_MANAGER -- requirements
Module: ahb_manager

Interface
REQ-001 Parameter ADDR_W, default 3, haddr/cmd_addr width.
REQ-002 Parameter DATA_W, default 8, hwdata/hrdata width.
REQ-003 Parameter MAX_BEATS, default 4, maximum beats per command.
REQ-004 Ports SHALL be, in order:
- hclk  in  1  single clock; all logic SHALL be on posedge hclk.
- hreset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_W  start address.
- cmd_size  in  3  transfer size, bytes = 2^cmd_size.
- cmd_beats  in  3  beat count.
- wr_data  in  DATA_W  write beat data, sampled when wr_ready=1.
- wr_ready  out  1  write beat consumed this cycle.
- rd_data  out  DATA_W  captured read beat.
- rd_valid  out  1  rd_data valid, one-cycle pulse per beat.
- done  out  1  one-cycle pulse, command finished.
- err  out  1  one-cycle pulse, command aborted or rejected.
- haddr  out  ADDR_W, htrans  out  2, hwrite  out  1, hsize  out  3, hwdata  out  DATA_W  AHB manager outputs.
- hrdata  in  DATA_W, hready  in  1, hresp  in  1  AHB subordinate responses.

Function
REQ-005 FSM states SHALL be IDLE, ADDR, BURST, LAST, ERR.
REQ-006 cmd_ready SHALL be 1 only in IDLE.
REQ-007 On accept (cycle T), registers SHALL latch command; beat-0 address phase (htrans=NONSEQ) SHALL drive in T+1.
REQ-008 cmd_beats=0 SHALL be treated as 1; values >MAX_BEATS SHALL clamp to MAX_BEATS.
REQ-009 cmd_size>log2(DATA_W/8) SHALL not start a transfer; err SHALL pulse at T+1, FSM stays IDLE.
REQ-010 Beats 1..N-1 SHALL use htrans=SEQ, haddr incremented by 2^hsize modulo 2^ADDR_W (wrap permitted).
REQ-011 Address phase of beat k+1 SHALL overlap data phase of beat k (pipelined); all AHB outputs SHALL hold while hready=0.
REQ-012 After final address phase, FSM SHALL enter LAST, drive htrans=IDLE, and wait for final data phase hready=1.
REQ-013 Writes: wr_ready SHALL pulse in the cycle a beat's address phase is accepted (hready=1); wr_data SHALL be registered onto hwdata for that beat's data phase, held until hready=1.
REQ-014 Reads: hrdata SHALL be captured when hready=1 in a read data phase; rd_valid/rd_data SHALL appear the following cycle.
REQ-015 done SHALL pulse the cycle after the final data phase completes with hresp=0; FSM returns IDLE same edge.
REQ-016 hresp=1 with hready=0 (first error cycle): manager SHALL drive htrans=IDLE that cycle (cancel pending beat), enter ERR.
REQ-017 In ERR, on hready=1 (second error cycle), err SHALL pulse next cycle, FSM returns IDLE, no done pulse; no rd_valid for the errored beat.
REQ-018 htrans=BUSY SHALL never be driven.
REQ-019 Single-beat command latency: accept T, address T+1, data T+2 (zero wait), done T+3.

Reset
REQ-020 hreset_n low SHALL immediately force: FSM IDLE, htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0, rd_data=0, and cmd_ready=0, wr_ready, rd_valid, done, err all 0.
REQ-021 Reset mid-burst SHALL discard the command with no done/err pulse; cmd_ready=1 first cycle after release.

Structure
REQ-022 Shared package ahb_pkg SHALL hold htrans_t (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11), hsize constants and the FSM state typedef.
REQ-023 Beat counter and address incrementer SHALL be sub-module ahb_manager_addr_gen.

Verification
REQ-024 Write addr=2, size=0, beats=1, zero wait -> NONSEQ haddr=2 at T+1, hwdata=wr_data at T+2, done at T+3.
REQ-025 Read addr=6, beats=4, size=0 -> haddr 6,7,0,1 (wrap), NONSEQ then 3×SEQ, 4 rd_valid pulses, one done.
REQ-026 Write beats=3 with hready=0 two cycles on beat 1 -> haddr/htrans/hwdata held, wr_ready pulses exactly 3.
REQ-027 Read beats=4, hresp=1 on beat 2 (hready 0 then 1) -> htrans=IDLE in first error cycle, err pulse, no done, 1 rd_valid.
REQ-028 cmd_size=1 -> err at T+1, htrans stays IDLE; hreset_n low mid-burst -> outputs to reset values immediately, no done/err.
